// File: rtl/tlc_pkg.sv
// ============================================================================
// Module   : tlc_pkg
// Purpose  : Lamp codes, FSM state type and lamp decode for the traffic light.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlc_pkg;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    typedef enum logic [1:0] {
        MG = 2'd0,
        MY = 2'd1,
        SG = 2'd2,
        SY = 2'd3
    } state_t;

    // Returns {main_road, side_road}; every state keeps at least one road RED.
    function automatic logic [3:0] lamps(input state_t s);
        logic [3:0] code;
        code = {RED, RED};
        case (s)
            MG: code = {GREEN,  RED};
            MY: code = {YELLOW, RED};
            SG: code = {RED,    GREEN};
            SY: code = {RED,    YELLOW};
            default: code = {RED, RED};
        endcase
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tlc_if.sv
// ============================================================================
// Module   : tlc_if
// Purpose  : Bundle of the road-side signals: vehicle sensor and both lamps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tlc_if;
    import tlc_pkg::*;

    logic       sensor;
    logic [1:0] main_road;
    logic [1:0] side_road;

    // master drives the sensor (road side), slave drives the lamps (controller)
    modport master (output sensor, input main_road, input side_road);
    modport slave  (input sensor, output main_road, output side_road);

endinterface

`default_nettype wire

// File: rtl/tlc_timer.sv
// ============================================================================
// Module   : tlc_timer
// Purpose  : 8-bit dwell counter, cleared on reset or state change, saturating.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlc_timer (
    input  wire logic       clock,
    input  wire logic       reset,
    input  wire logic       clear,
    output logic      [7:0] count
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= 8'd0;
        end else if (count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tlc.sv
// ============================================================================
// Module   : tlc
// Purpose  : Main/side road traffic-light controller with side-road sensor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlc
    import tlc_pkg::*;
#(
    parameter int MAIN_MIN_GREEN    = 6,
    parameter int YELLOW_CYCLES     = 3,
    parameter int SIDE_GREEN_CYCLES = 5
) (
    input  wire logic       clock,
    input  wire logic       reset,
    input  wire logic       sensor,
    output logic      [1:0] main_road,
    output logic      [1:0] side_road
);

    localparam logic [7:0] c_main_last   = 8'(MAIN_MIN_GREEN - 1);
    localparam logic [7:0] c_yellow_last = 8'(YELLOW_CYCLES - 1);
    localparam logic [7:0] c_side_last   = 8'(SIDE_GREEN_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] w_count;
    logic       w_clear;

    tlc_timer u_timer (
        .clock (clock),
        .reset (reset),
        .clear (w_clear),
        .count (w_count)
    );

    // Only a solid 1 on sensor is a request; it is never remembered.
    always_comb begin
        w_next = r_state;
        case (r_state)
            MG: if ((sensor == 1'b1) && (w_count >= c_main_last)) w_next = MY;
            MY: if (w_count == c_yellow_last) w_next = SG;
            SG: if (w_count == c_side_last)   w_next = SY;
            SY: if (w_count == c_yellow_last) w_next = MG;
            default: w_next = MG;
        endcase
    end

    assign w_clear = (w_next != r_state);

    // Lamps are registered from the next state so they track r_state exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= MG;
            main_road <= GREEN;
            side_road <= RED;
        end else begin
            r_state                <= w_next;
            {main_road, side_road} <= lamps(w_next);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tlc.sv
// ============================================================================
// Module   : tb_tlc
// Purpose  : Directed plus random checks of tlc against a phase/dwell model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tlc;
    import tlc_pkg::*;

    localparam int MIN_GREEN  = 6;
    localparam int YEL        = 3;
    localparam int SIDE_GREEN = 5;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase 0..3 = main green, main yellow, side green, side yellow
    int         m_phase;
    int         m_elapsed;
    logic [1:0] main_of [4];
    logic [1:0] side_of [4];

    tlc_if bus ();

    tlc #(
        .MAIN_MIN_GREEN    (MIN_GREEN),
        .YELLOW_CYCLES     (YEL),
        .SIDE_GREEN_CYCLES (SIDE_GREEN)
    ) dut (
        .clock     (clk),
        .reset     (rst),
        .sensor    (bus.sensor),
        .main_road (bus.main_road),
        .side_road (bus.side_road)
    );

    always #5 clk = ~clk;

    function automatic int phase_len(input int p);
        if (p == 0) return MIN_GREEN;
        if (p == 2) return SIDE_GREEN;
        return YEL;
    endfunction

    task automatic model_edge(input logic r, input logic s);
        int  held;
        bit  leave;
        if (r === 1'b1) begin
            m_phase   = 0;
            m_elapsed = 0;
        end else begin
            held  = m_elapsed + 1;
            leave = (m_phase == 0) ? ((s === 1'b1) && (held >= MIN_GREEN))
                                   : (held >= phase_len(m_phase));
            if (leave) begin
                m_phase   = (m_phase + 1) % 4;
                m_elapsed = 0;
            end else begin
                m_elapsed = (held > 255) ? 255 : held;
            end
        end
    endtask

    task automatic check_code(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive inputs, take one edge, then compare against the model away from the edge.
    task automatic step(input logic r, input logic s);
        rst        = r;
        bus.sensor = s;
        @(posedge clk);
        model_edge(r, s);
        #1;
        check_code("model_main", bus.main_road, main_of[m_phase]);
        check_code("model_side", bus.side_road, side_of[m_phase]);
        check_int("one_road_red",
                  int'((bus.main_road === RED) || (bus.side_road === RED)), 1);
    endtask

    logic [1:0] exp_main [13];
    logic [1:0] exp_side [13];
    int         mg_len;
    int         period;
    logic [1:0] prev_main;

    initial begin
        main_of = '{GREEN, YELLOW, RED, RED};
        side_of = '{RED, RED, GREEN, YELLOW};
        exp_main = '{YELLOW, YELLOW, YELLOW, RED, RED, RED, RED, RED, RED, RED, RED, GREEN, GREEN};
        exp_side = '{RED, RED, RED, GREEN, GREEN, GREEN, GREEN, GREEN, YELLOW, YELLOW, YELLOW, RED, RED};
        m_phase   = 0;
        m_elapsed = 0;
        rst        = 1'b1;
        bus.sensor = 1'b0;
        #2;

        // Reset for one edge
        step(1'b1, 1'b0);
        check_code("reset_main", bus.main_road, GREEN);
        check_code("reset_side", bus.side_road, RED);

        // No request: main stays green for 30 cycles
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0);
            check_code("noreq_main", bus.main_road, GREEN);
            check_code("noreq_side", bus.side_road, RED);
        end

        // Single request held 10 cycles, then released
        for (int i = 0; i < 13; i++) begin
            step(1'b0, (i < 10) ? 1'b1 : 1'b0);
            check_code("single_main", bus.main_road, exp_main[i]);
            check_code("single_side", bus.side_road, exp_side[i]);
        end

        // Minimum green with sensor high straight after reset, then full period
        step(1'b1, 1'b0);
        mg_len = 1;
        for (int i = 0; i < 20 && bus.main_road === GREEN; i++) begin
            step(1'b0, 1'b1);
            if (bus.main_road === GREEN) mg_len++;
        end
        check_int("min_green_len", mg_len, MIN_GREEN);
        check_code("min_green_then_yellow", bus.main_road, YELLOW);
        period = 0;
        for (int i = 0; i < 40; i++) begin
            prev_main = bus.main_road;
            step(1'b0, 1'b1);
            period++;
            if (prev_main === GREEN && bus.main_road === YELLOW) break;
        end
        check_int("cycle_period", period, 17);

        // Reset in the middle of side green
        for (int i = 0; i < 30 && bus.side_road !== GREEN; i++) step(1'b0, 1'b1);
        check_code("reach_side_green", bus.side_road, GREEN);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check_code("midreset_main", bus.main_road, GREEN);
        check_code("midreset_side", bus.side_road, RED);
        mg_len = 1;
        for (int i = 0; i < 20 && bus.main_road === GREEN; i++) begin
            step(1'b0, 1'b1);
            if (bus.main_road === GREEN) mg_len++;
        end
        check_int("midreset_min_green", mg_len, MIN_GREEN);

        // Short pulse before the minimum is lost; X never counts as a request
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            check_code("pulse_ignored", bus.main_road, GREEN);
        end
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 1'bx);
            check_code("x_ignored", bus.main_road, GREEN);
        end

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
